// File: rtl/cdc_2phase_arb_pkg.sv
// Shared types for the two-phase CDC source-side arbiter/clear controller.
package cdc_2phase_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-one finder: lowest set request at or after start_i, wrapping.
module rr_pick #(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   start_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  int unsigned pos;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = (32'(start_i) + k) % NumReq;
      if (!valid_o && req_i[IdxW'(pos)]) begin
        idx_o   = IdxW'(pos);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_2phase_src_arb_ctrl.sv
// Round-robin arbiter in front of a clearable two-phase CDC source half,
// sequencing drain -> clear -> done without ever presenting valid during clear.
module cdc_2phase_src_arb_ctrl
  import cdc_2phase_arb_pkg::*;
#(
  parameter  int unsigned NumReq       = 4,
  parameter  int unsigned ClearCycles  = 2,
  parameter  int unsigned DrainTimeout = 64,
  localparam int unsigned IdxW         = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_valid_i,
  input  logic [NumReq-1:0] req_data_i,
  output logic [NumReq-1:0] req_ready_o,
  output logic              src_valid_o,
  output logic              src_data_o,
  input  logic              src_ready_i,
  output logic              src_clear_o,
  input  logic              clear_req_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  output logic              drain_timeout_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  localparam int unsigned CntMax = (ClearCycles > DrainTimeout) ? ClearCycles : DrainTimeout;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] held_q, held_d;
  logic            locked_q, locked_d;
  logic            pend_q, pend_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CntW-1:0] clr_cnt_q, clr_cnt_d;
  logic            timeout_q, timeout_d;

  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic [IdxW-1:0] grant;
  logic            hs;
  logic            stall;

  rr_pick #(
    .NumReq(NumReq)
  ) u_rr_pick (
    .req_i  (req_valid_i),
    .start_i(rr_ptr_q),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    held_d      = held_q;
    locked_d    = locked_q;
    pend_d      = pend_q;
    drain_cnt_d = '0;
    clr_cnt_d   = '0;
    timeout_d   = timeout_q;
    hs          = 1'b0;
    stall       = 1'b0;

    src_valid_o  = 1'b0;
    src_data_o   = 1'b0;
    src_clear_o  = 1'b0;
    clear_done_o = 1'b0;
    req_ready_o  = '0;

    grant       = locked_q ? held_q : pick_idx;
    grant_idx_o = grant;

    unique case (state_q)
      ARB: begin
        src_valid_o        = locked_q ? req_valid_i[held_q] : pick_valid;
        src_data_o         = src_valid_o & req_data_i[grant];
        req_ready_o[grant] = src_ready_i;
        hs                 = src_valid_o & src_ready_i;
        stall              = src_valid_o & ~src_ready_i;

        // The lock simply mirrors an outstanding stall, so it drops on the
        // handshake and never survives into DRAIN.
        locked_d = stall;
        if (stall) held_d = grant;
        if (hs) rr_ptr_d = (grant == LastIdx) ? '0 : grant + 1'b1;

        // A clear request seen while stalled is remembered until the item
        // completes, since the request may be only a pulse.
        if ((clear_req_i || pend_q) && !stall) begin
          state_d = DRAIN;
          pend_d  = 1'b0;
        end else if (clear_req_i) begin
          pend_d = 1'b1;
        end
      end

      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (src_ready_i) begin
          state_d     = CLEAR;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == CntW'(DrainTimeout - 1)) begin
          state_d     = CLEAR;
          drain_cnt_d = '0;
          timeout_d   = 1'b1;
        end
      end

      CLEAR: begin
        src_clear_o = 1'b1;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CntW'(ClearCycles - 1)) begin
          state_d   = DONE;
          clr_cnt_d = '0;
        end
      end

      DONE: begin
        clear_done_o = 1'b1;
        state_d      = clear_req_i ? DRAIN : ARB;
      end

      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      held_q      <= '0;
      locked_q    <= 1'b0;
      pend_q      <= 1'b0;
      drain_cnt_q <= '0;
      clr_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      held_q      <= held_d;
      locked_q    <= locked_d;
      pend_q      <= pend_d;
      drain_cnt_q <= drain_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign clear_busy_o    = (state_q != ARB);
  assign drain_timeout_o = timeout_q;

endmodule

// File: tb/tb_cdc_2phase_src_arb_ctrl.sv
// Scoreboard bench for cdc_2phase_src_arb_ctrl: arbitration order, lock, clear sequencing.
module tb_cdc_2phase_src_arb_ctrl;

  localparam int unsigned NumReq       = 4;
  localparam int unsigned ClearCycles  = 2;
  localparam int unsigned DrainTimeout = 8;
  localparam int unsigned IdxW         = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0] req_data_i;
  logic [NumReq-1:0] req_ready_o;
  logic              src_valid_o;
  logic              src_data_o;
  logic              src_ready_i;
  logic              src_clear_o;
  logic              clear_req_i;
  logic              clear_busy_o;
  logic              clear_done_o;
  logic              drain_timeout_o;
  logic [IdxW-1:0]   grant_idx_o;

  cdc_2phase_src_arb_ctrl #(
    .NumReq      (NumReq),
    .ClearCycles (ClearCycles),
    .DrainTimeout(DrainTimeout)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .src_valid_o    (src_valid_o),
    .src_data_o     (src_data_o),
    .src_ready_i    (src_ready_i),
    .src_clear_o    (src_clear_o),
    .clear_req_i    (clear_req_i),
    .clear_busy_o   (clear_busy_o),
    .clear_done_o   (clear_done_o),
    .drain_timeout_o(drain_timeout_o),
    .grant_idx_o    (grant_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic            data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IdxW-1:0] idx);
    exp_t e;
    e.idx  = idx;
    e.data = req_data_i[idx];
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Handshake scoreboard, lock stability and the clear/valid exclusion.
  logic            prev_stall = 1'b0;
  logic [IdxW-1:0] prev_idx   = '0;
  exp_t            got;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall <= 1'b0;
    end else begin
      chk("clr_and_valid", 32'(src_clear_o & src_valid_o), 0);
      if (prev_stall) begin
        chk("lock_valid", 32'(src_valid_o), 1);
        chk("lock_idx", 32'(grant_idx_o), 32'(prev_idx));
      end
      if (src_valid_o && src_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("hs_unexpected", 32'(exp_q.size()), 1);
        end else begin
          got = exp_q.pop_front();
          chk("hs_idx", 32'(grant_idx_o), 32'(got.idx));
          chk("hs_data", 32'(src_data_o), 32'(got.data));
        end
      end
      prev_stall <= src_valid_o & ~src_ready_i;
      prev_idx   <= grant_idx_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned     drain_n;
    int unsigned     arb_n;
    int unsigned     done_n;
    logic            seen;
    logic [IdxW-1:0] nidx;

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    src_ready_i = 1'b0;
    clear_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset values
    smp();
    chk("rst_src_valid", 32'(src_valid_o), 0);
    chk("rst_src_clear", 32'(src_clear_o), 0);
    chk("rst_busy", 32'(clear_busy_o), 0);
    chk("rst_done", 32'(clear_done_o), 0);
    chk("rst_timeout", 32'(drain_timeout_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_grant", 32'(grant_idx_o), 0);
    nxt();

    // All requesting, ready always high: one grant per cycle in rotation
    req_data_i  = 4'b1010;
    req_valid_i = 4'b1111;
    src_ready_i = 1'b1;
    for (int unsigned k = 0; k < 8; k++) push(IdxW'(k));
    for (int unsigned k = 0; k < 8; k++) begin
      smp();
      chk("p1_ready", 32'(req_ready_o), 32'(1) << (k % 4));
      nxt();
    end
    req_valid_i = '0;
    src_ready_i = 1'b0;
    smp();
    chk("p1_all_popped", 32'(exp_q.size()), 0);
    nxt();

    // Lock on requester 0 while requester 1 rises, then 0 then 2
    req_data_i = 4'b0100;
    for (int unsigned c = 0; c < 3; c++) begin
      req_valid_i = (c == 1) ? 4'b0111 : 4'b0101;
      smp();
      chk("p2_lock_grant", 32'(grant_idx_o), 0);
      chk("p2_lock_valid", 32'(src_valid_o), 1);
      chk("p2_lock_ready", 32'(req_ready_o), 0);
      nxt();
    end
    req_valid_i = 4'b0101;
    src_ready_i = 1'b1;
    push(2'd0);
    push(2'd2);
    repeat (2) begin
      smp();
      nxt();
    end
    req_valid_i = '0;
    src_ready_i = 1'b0;

    // Clear pulse while locked on requester 3: item completes, then drain/clear/done
    req_valid_i = 4'b1000;
    req_data_i  = 4'b1000;
    clear_req_i = 1'b1;
    smp();
    chk("p3_grant", 32'(grant_idx_o), 3);
    chk("p3_busy0", 32'(clear_busy_o), 0);
    nxt();
    clear_req_i = 1'b0;
    smp();
    chk("p3_hold_grant", 32'(grant_idx_o), 3);
    chk("p3_busy1", 32'(clear_busy_o), 0);
    nxt();
    src_ready_i = 1'b1;
    push(2'd3);
    smp();
    chk("p3_busy_hs", 32'(clear_busy_o), 0);
    nxt();
    req_valid_i = 4'b0001;
    req_data_i  = '0;
    smp();
    chk("p3_drain_busy", 32'(clear_busy_o), 1);
    chk("p3_drain_valid", 32'(src_valid_o), 0);
    chk("p3_drain_clear", 32'(src_clear_o), 0);
    nxt();
    for (int unsigned c = 0; c < ClearCycles; c++) begin
      smp();
      chk("p3_clear", 32'(src_clear_o), 1);
      chk("p3_clear_valid", 32'(src_valid_o), 0);
      chk("p3_clear_done", 32'(clear_done_o), 0);
      nxt();
    end
    smp();
    chk("p3_done", 32'(clear_done_o), 1);
    chk("p3_done_clear", 32'(src_clear_o), 0);
    chk("p3_done_valid", 32'(src_valid_o), 0);
    nxt();
    push(2'd0);
    smp();
    chk("p3_arb_busy", 32'(clear_busy_o), 0);
    chk("p3_arb_done", 32'(clear_done_o), 0);
    chk("p3_no_timeout", 32'(drain_timeout_o), 0);
    nxt();
    req_valid_i = '0;
    src_ready_i = 1'b0;

    // Drain timeout with ready held low
    clear_req_i = 1'b1;
    smp();
    nxt();
    clear_req_i = 1'b0;
    drain_n = 0;
    seen    = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      smp();
      if (i == 0) chk("p4_timeout_pre", 32'(drain_timeout_o), 0);
      if (src_clear_o) begin
        seen = 1'b1;
        break;
      end
      if (clear_busy_o) drain_n++;
      nxt();
    end
    chk("p4_clear_seen", 32'(seen), 1);
    chk("p4_drain_cycles", drain_n, DrainTimeout);
    chk("p4_timeout_set", 32'(drain_timeout_o), 1);
    nxt();
    for (int unsigned i = 0; i < 10; i++) begin
      smp();
      if (!clear_busy_o) break;
      nxt();
    end
    chk("p4_back_arb", 32'(clear_busy_o), 0);
    nxt();
    repeat (3) nxt();
    smp();
    chk("p4_sticky", 32'(drain_timeout_o), 1);
    nxt();

    // Reset during the second CLEAR cycle
    src_ready_i = 1'b1;
    clear_req_i = 1'b1;
    smp();
    nxt();
    clear_req_i = 1'b0;
    smp();
    nxt();
    smp();
    chk("p5_clear1", 32'(src_clear_o), 1);
    nxt();
    rst_i = 1'b1;
    smp();
    chk("p5_clear2", 32'(src_clear_o), 1);
    nxt();
    rst_i       = 1'b0;
    req_valid_i = 4'b1111;
    req_data_i  = 4'b0001;
    push(2'd0);
    smp();
    chk("p5_rst_clear", 32'(src_clear_o), 0);
    chk("p5_rst_busy", 32'(clear_busy_o), 0);
    chk("p5_rst_timeout", 32'(drain_timeout_o), 0);
    chk("p5_rst_done", 32'(clear_done_o), 0);
    chk("p5_rst_grant", 32'(grant_idx_o), 0);
    nxt();
    req_valid_i = '0;

    // Level clear held: back-to-back sequences, no ARB gap
    clear_req_i = 1'b1;
    smp();
    chk("p6_first_arb", 32'(clear_busy_o), 0);
    nxt();
    arb_n  = 0;
    done_n = 0;
    for (int unsigned i = 0; i < 19; i++) begin
      req_valid_i = 4'($urandom_range(0, 15));
      req_data_i  = 4'($urandom_range(0, 15));
      smp();
      if (!clear_busy_o) arb_n++;
      if (clear_done_o) done_n++;
      nxt();
    end
    clear_req_i = 1'b0;
    req_valid_i = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      smp();
      if (!clear_busy_o) break;
      nxt();
    end
    chk("p6_arb_gap", arb_n, 0);
    chk("p6_done_pulses", done_n, 4);
    chk("p6_idle", 32'(clear_busy_o), 0);
    nxt();

    // Random ready with all requesting: rotation continues from rr_ptr=1
    req_valid_i = 4'b1111;
    req_data_i  = 4'b0110;
    nidx        = 2'd1;
    for (int unsigned i = 0; i < 40; i++) begin
      src_ready_i = 1'($urandom_range(0, 1));
      if (src_ready_i) begin
        push(nidx);
        nidx = nidx + 1'b1;
      end
      smp();
      nxt();
    end
    src_ready_i = 1'b1;
    push(nidx);
    smp();
    nxt();
    req_valid_i = '0;
    src_ready_i = 1'b0;

    smp();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
